// File: rtl/reg_writeback_unit_pkg.sv
// Shared definitions for the writeback slice.
// - Load funct3 encodings consumed by the load formatter.
// - Load FSM state type.
// - Default link register for interrupt-entry PC save.
package reg_writeback_unit_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        LOAD_IDLE,
        LOAD_WAIT
    } load_state_e;

    localparam int unsigned DEF_IRQ_LINK_REG = 30;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Bundle of EX, data-memory, decode, IRQ and register-file signals around
// the writeback unit.
// - master: the surrounding pipeline (drives EX/MEM/DEC/IRQ requests).
// - slave : the writeback unit (drives RF_*, IRQ_ACK and the stall outputs).
interface reg_writeback_unit_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  EX_VALID;
    logic                  EX_IS_LOAD;
    logic [REG_ADDR_W-1:0] EX_RD;
    logic [31:0]           EX_RESULT;
    logic [2:0]            EX_FUNCT3;
    logic [1:0]            EX_ADDR_LSB;
    logic                  MEM_BUSY;
    logic [31:0]           MEM_READDATA;
    logic [REG_ADDR_W-1:0] DEC_RS1;
    logic [REG_ADDR_W-1:0] DEC_RS2;
    logic [REG_ADDR_W-1:0] DEC_RD;
    logic                  IRQ_SAVE;
    logic [31:0]           IRQ_PC;
    logic                  IRQ_ACK;
    logic [31:0]           RF_IN;
    logic [REG_ADDR_W-1:0] RF_INADDRESS;
    logic                  RF_WRITE_EN;
    logic                  PIPE_STALL;
    logic                  HAZARD_STALL;

    modport master (
        output EX_VALID, EX_IS_LOAD, EX_RD, EX_RESULT, EX_FUNCT3, EX_ADDR_LSB,
        output MEM_BUSY, MEM_READDATA, DEC_RS1, DEC_RS2, DEC_RD,
        output IRQ_SAVE, IRQ_PC,
        input  IRQ_ACK, RF_IN, RF_INADDRESS, RF_WRITE_EN, PIPE_STALL, HAZARD_STALL
    );

    modport slave (
        input  EX_VALID, EX_IS_LOAD, EX_RD, EX_RESULT, EX_FUNCT3, EX_ADDR_LSB,
        input  MEM_BUSY, MEM_READDATA, DEC_RS1, DEC_RS2, DEC_RD,
        input  IRQ_SAVE, IRQ_PC,
        output IRQ_ACK, RF_IN, RF_INADDRESS, RF_WRITE_EN, PIPE_STALL, HAZARD_STALL
    );

endinterface

// File: rtl/reg_writeback_unit_load_formatter.sv
// Combinational load data formatter.
// Ports:
// - funct3 : load type (LB/LH/LW/LBU/LHU; any other code returns the word).
// - lsb    : byte offset of the load address.
// - word   : aligned memory word.
// - data   : byte/halfword extracted and sign/zero-extended.
module load_formatter
    import reg_writeback_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lsb,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lsb, 3'b000} +: 8];
        half_sel = lsb[1] ? word[31:16] : word[15:0];
        case (funct3)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'h0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'h0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage owning the register file's single write port.
// Merges ALU results, one outstanding non-blocking load and the interrupt
// PC save; keeps a one-entry skid buffer for ALU results that lose the port.
// Ports:
// - CLK, RESET : clock and synchronous active-high reset.
// - bus        : slave side of reg_writeback_unit_if (EX/MEM/DEC/IRQ inputs;
//                registered RF_IN/RF_INADDRESS/RF_WRITE_EN/IRQ_ACK outputs;
//                combinational PIPE_STALL and HAZARD_STALL).
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned IRQ_LINK_REG = DEF_IRQ_LINK_REG
)(
    input logic                 CLK,
    input logic                 RESET,
    reg_writeback_unit_if.slave bus
);

    localparam logic [REG_ADDR_W-1:0] LINK_ADDR = REG_ADDR_W'(IRQ_LINK_REG);

    load_state_e           state_q, state_d;
    logic [REG_ADDR_W-1:0] ld_rd_q;
    logic [2:0]            ld_f3_q;
    logic [1:0]            ld_lsb_q;
    logic                  skid_full_q;
    logic [REG_ADDR_W-1:0] skid_rd_q;
    logic [31:0]           skid_data_q;
    logic [31:0]           rf_in_q;
    logic [REG_ADDR_W-1:0] rf_addr_q;
    logic                  rf_we_q;
    logic                  irq_ack_q;

    logic                  load_outstanding, load_return, load_wr;
    logic                  pipe_stall, accept, accept_load, alu_wr, irq_grant;
    logic                  pending_valid;
    logic [31:0]           ld_data;
    logic                  sel_we, sel_ack, skid_push, skid_pop;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [31:0]           sel_data;

    load_formatter u_fmt (
        .funct3 (ld_f3_q),
        .lsb    (ld_lsb_q),
        .word   (bus.MEM_READDATA),
        .data   (ld_data)
    );

    always_comb begin
        load_outstanding = (state_q == LOAD_WAIT);
        load_return      = load_outstanding & ~bus.MEM_BUSY;
        // A load to x0 still completes but never claims the write port.
        load_wr          = load_return & (|ld_rd_q);
        pipe_stall       = skid_full_q | (bus.EX_VALID & bus.EX_IS_LOAD & load_outstanding);
        accept           = bus.EX_VALID & ~pipe_stall;
        accept_load      = accept & bus.EX_IS_LOAD;
        alu_wr           = accept & ~bus.EX_IS_LOAD & (|bus.EX_RD);
        irq_grant        = bus.IRQ_SAVE & ~load_outstanding & ~skid_full_q & ~accept;
        // Scoreboard entry clears in the return cycle so decode can proceed.
        pending_valid    = load_outstanding & ~load_return & (|ld_rd_q);
    end

    assign bus.PIPE_STALL   = pipe_stall;
    assign bus.HAZARD_STALL = pending_valid &
                              ((bus.DEC_RS1 == ld_rd_q) |
                               (bus.DEC_RS2 == ld_rd_q) |
                               (bus.DEC_RD  == ld_rd_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_IDLE: if (accept_load)   state_d = LOAD_WAIT;
            LOAD_WAIT: if (!bus.MEM_BUSY) state_d = LOAD_IDLE;
            default:                      state_d = LOAD_IDLE;
        endcase
    end

    // Skid full and a new accept are mutually exclusive (full stalls EX), so
    // at most one ALU result is ever competing with the load for the port.
    always_comb begin
        sel_we    = 1'b0;
        sel_ack   = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        skid_push = 1'b0;
        skid_pop  = 1'b0;
        if (load_wr) begin
            sel_we    = 1'b1;
            sel_addr  = ld_rd_q;
            sel_data  = ld_data;
            skid_push = alu_wr;
        end else if (skid_full_q) begin
            sel_we    = 1'b1;
            sel_addr  = skid_rd_q;
            sel_data  = skid_data_q;
            skid_pop  = 1'b1;
        end else if (alu_wr) begin
            sel_we    = 1'b1;
            sel_addr  = bus.EX_RD;
            sel_data  = bus.EX_RESULT;
        end else if (irq_grant) begin
            sel_we    = 1'b1;
            sel_ack   = 1'b1;
            sel_addr  = LINK_ADDR;
            sel_data  = bus.IRQ_PC;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= LOAD_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ld_rd_q     <= '0;
            ld_f3_q     <= '0;
            ld_lsb_q    <= '0;
            skid_full_q <= 1'b0;
            skid_rd_q   <= '0;
            skid_data_q <= '0;
            rf_in_q     <= '0;
            rf_addr_q   <= '0;
            rf_we_q     <= 1'b0;
            irq_ack_q   <= 1'b0;
        end else begin
            if (accept_load) begin
                ld_rd_q  <= bus.EX_RD;
                ld_f3_q  <= bus.EX_FUNCT3;
                ld_lsb_q <= bus.EX_ADDR_LSB;
            end
            if (skid_push) begin
                skid_full_q <= 1'b1;
                skid_rd_q   <= bus.EX_RD;
                skid_data_q <= bus.EX_RESULT;
            end else if (skid_pop) begin
                skid_full_q <= 1'b0;
            end
            rf_in_q   <= sel_data;
            rf_addr_q <= sel_addr;
            rf_we_q   <= sel_we;
            irq_ack_q <= sel_ack;
        end
    end

    assign bus.RF_IN        = rf_in_q;
    assign bus.RF_INADDRESS = rf_addr_q;
    assign bus.RF_WRITE_EN  = rf_we_q;
    assign bus.IRQ_ACK      = irq_ack_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
module tb_reg_writeback_unit;
    import reg_writeback_unit_pkg::*;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ack;
    } wr_t;

    logic CLK;
    logic RESET;
    int   n_cmp;
    int   n_mis;
    wr_t  exp_q[$];

    reg_writeback_unit_if #(.REG_ADDR_W(5)) bus();

    reg_writeback_unit #(
        .REG_ADDR_W   (5),
        .IRQ_LINK_REG (30)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] addr, input logic [31:0] data, input logic ack);
        wr_t e;
        e.addr = addr;
        e.data = data;
        e.ack  = ack;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.EX_VALID     = 1'b0;
        bus.EX_IS_LOAD   = 1'b0;
        bus.EX_RD        = '0;
        bus.EX_RESULT    = '0;
        bus.EX_FUNCT3    = '0;
        bus.EX_ADDR_LSB  = '0;
        bus.MEM_BUSY     = 1'b1;
        bus.MEM_READDATA = '0;
        bus.DEC_RS1      = '0;
        bus.DEC_RS2      = '0;
        bus.DEC_RD       = '0;
        bus.IRQ_SAVE     = 1'b0;
        bus.IRQ_PC       = '0;
    endtask

    // Scoreboard: every RF write must match the oldest expected write.
    always @(negedge CLK) begin
        if (bus.RF_WRITE_EN === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {27'h0, bus.RF_INADDRESS}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {27'h0, bus.RF_INADDRESS}, {27'h0, e.addr});
                check("wr_data", bus.RF_IN, e.data);
                check("wr_ack", {31'h0, bus.IRQ_ACK}, {31'h0, e.ack});
            end
        end else if (!RESET) begin
            check("ack_without_wr", {31'h0, bus.IRQ_ACK}, 32'h0);
        end
    end

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lsb,
                           input logic [31:0] word, input int busy, input logic [31:0] exp);
        bus.EX_VALID    = 1'b1;
        bus.EX_IS_LOAD  = 1'b1;
        bus.EX_RD       = rd;
        bus.EX_FUNCT3   = f3;
        bus.EX_ADDR_LSB = lsb;
        bus.MEM_BUSY    = 1'b1;
        #1 check("ld_accept_pstall", {31'h0, bus.PIPE_STALL}, 32'h0);
        tick();
        bus.EX_VALID = 1'b0;
        bus.DEC_RS1  = rd;
        for (int i = 0; i < busy; i++) begin
            #1 check("ld_hz_busy", {31'h0, bus.HAZARD_STALL}, {31'h0, rd != 5'd0});
            tick();
        end
        bus.MEM_BUSY     = 1'b0;
        bus.MEM_READDATA = word;
        #1 check("ld_hz_ret", {31'h0, bus.HAZARD_STALL}, 32'h0);
        if (rd != 5'd0) push(rd, exp, 1'b0);
        tick();
        bus.MEM_BUSY = 1'b1;
        bus.DEC_RS1  = '0;
    endtask

    initial begin
        logic [31:0] r;
        n_cmp = 0;
        n_mis = 0;
        idle();
        RESET = 1'b1;
        tick();
        tick();
        check("rst_we",     {31'h0, bus.RF_WRITE_EN}, 32'h0);
        check("rst_in",     bus.RF_IN, 32'h0);
        check("rst_addr",   {27'h0, bus.RF_INADDRESS}, 32'h0);
        check("rst_ack",    {31'h0, bus.IRQ_ACK}, 32'h0);
        check("rst_pstall", {31'h0, bus.PIPE_STALL}, 32'h0);
        check("rst_hz",     {31'h0, bus.HAZARD_STALL}, 32'h0);
        RESET = 1'b0;

        // Single ALU write.
        bus.EX_VALID  = 1'b1;
        bus.EX_RD     = 5'd5;
        bus.EX_RESULT = 32'hDEAD_BEEF;
        push(5'd5, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("alu_we", {31'h0, bus.RF_WRITE_EN}, 32'h1);
        bus.EX_VALID = 1'b0;
        tick();
        check("alu_we_drop", {31'h0, bus.RF_WRITE_EN}, 32'h0);

        // Back-to-back ALU writes.
        for (int i = 1; i <= 3; i++) begin
            r = $urandom;
            bus.EX_VALID  = 1'b1;
            bus.EX_RD     = 5'(i);
            bus.EX_RESULT = r;
            push(5'(i), r, 1'b0);
            tick();
        end
        bus.EX_VALID = 1'b0;
        tick();

        // ALU to x0: accepted, never written.
        bus.EX_VALID  = 1'b1;
        bus.EX_RD     = 5'd0;
        bus.EX_RESULT = 32'h5555_5555;
        #1 check("x0_pstall", {31'h0, bus.PIPE_STALL}, 32'h0);
        tick();
        bus.EX_VALID = 1'b0;
        tick();
        check("x0_we", {31'h0, bus.RF_WRITE_EN}, 32'h0);

        // Load formats.
        do_load(5'd10, LB,     2'd3, 32'h80FF_1234, 3, 32'hFFFF_FF80);
        do_load(5'd11, LHU,    2'd2, 32'h80FF_1234, 3, 32'h0000_80FF);
        do_load(5'd12, LW,     2'd0, 32'h80FF_1234, 3, 32'h80FF_1234);
        do_load(5'd13, LH,     2'd2, 32'h80FF_1234, 1, 32'hFFFF_80FF);
        do_load(5'd17, LH,     2'd0, 32'h80FF_1234, 1, 32'h0000_1234);
        do_load(5'd16, LBU,    2'd1, 32'h80FF_1234, 0, 32'h0000_0012);
        do_load(5'd18, LB,     2'd2, 32'h80FF_1234, 0, 32'hFFFF_FFFF);
        do_load(5'd19, 3'b011, 2'd1, 32'h80FF_1234, 0, 32'h80FF_1234);
        do_load(5'd0,  LW,     2'd0, 32'h80FF_1234, 2, 32'h0);

        // Collision: ALU accepted in the load-return cycle goes via skid.
        bus.EX_VALID   = 1'b1;
        bus.EX_IS_LOAD = 1'b1;
        bus.EX_RD      = 5'd9;
        bus.EX_FUNCT3  = LW;
        bus.MEM_BUSY   = 1'b1;
        tick();
        bus.EX_VALID = 1'b0;
        tick();
        bus.MEM_BUSY     = 1'b0;
        bus.MEM_READDATA = 32'hCAFE_0009;
        bus.EX_VALID     = 1'b1;
        bus.EX_IS_LOAD   = 1'b0;
        bus.EX_RD        = 5'd7;
        bus.EX_RESULT    = 32'h0000_0077;
        #1 check("col_accept", {31'h0, bus.PIPE_STALL}, 32'h0);
        push(5'd9, 32'hCAFE_0009, 1'b0);
        push(5'd7, 32'h0000_0077, 1'b0);
        tick();
        bus.MEM_BUSY  = 1'b1;
        bus.EX_RD     = 5'd8;
        bus.EX_RESULT = 32'h0000_0088;
        #1 check("col_skid_stall", {31'h0, bus.PIPE_STALL}, 32'h1);
        tick();
        #1 check("col_skid_drained", {31'h0, bus.PIPE_STALL}, 32'h0);
        push(5'd8, 32'h0000_0088, 1'b0);
        tick();
        bus.EX_VALID = 1'b0;
        tick();

        // Second load stalls through WAIT and its return cycle.
        bus.EX_VALID   = 1'b1;
        bus.EX_IS_LOAD = 1'b1;
        bus.EX_RD      = 5'd14;
        bus.EX_FUNCT3  = LW;
        bus.MEM_BUSY   = 1'b1;
        tick();
        bus.EX_RD       = 5'd15;
        bus.EX_FUNCT3   = LBU;
        bus.EX_ADDR_LSB = 2'd1;
        #1 check("ld2_stall_wait", {31'h0, bus.PIPE_STALL}, 32'h1);
        tick();
        bus.MEM_BUSY     = 1'b0;
        bus.MEM_READDATA = 32'h1122_3344;
        #1 check("ld2_stall_ret", {31'h0, bus.PIPE_STALL}, 32'h1);
        push(5'd14, 32'h1122_3344, 1'b0);
        tick();
        bus.MEM_BUSY = 1'b1;
        #1 check("ld2_accept", {31'h0, bus.PIPE_STALL}, 32'h0);
        tick();
        bus.EX_VALID = 1'b0;
        bus.DEC_RS2  = 5'd15;
        #1 check("ld2_hz_rs2", {31'h0, bus.HAZARD_STALL}, 32'h1);
        tick();
        bus.MEM_BUSY     = 1'b0;
        bus.MEM_READDATA = 32'hAABB_CCDD;
        #1 check("ld2_hz_ret", {31'h0, bus.HAZARD_STALL}, 32'h0);
        push(5'd15, 32'h0000_00CC, 1'b0);
        tick();
        bus.MEM_BUSY = 1'b1;
        bus.DEC_RS2  = '0;
        tick();

        // IRQ save with EX idle.
        bus.IRQ_SAVE = 1'b1;
        bus.IRQ_PC   = 32'h0000_0120;
        push(5'd30, 32'h0000_0120, 1'b1);
        tick();
        check("irq_ack", {31'h0, bus.IRQ_ACK}, 32'h1);
        bus.IRQ_SAVE = 1'b0;
        tick();
        check("irq_ack_drop", {31'h0, bus.IRQ_ACK}, 32'h0);

        // IRQ waits while EX keeps issuing.
        bus.IRQ_SAVE   = 1'b1;
        bus.IRQ_PC     = 32'h0000_0200;
        bus.EX_VALID   = 1'b1;
        bus.EX_IS_LOAD = 1'b0;
        bus.EX_RD      = 5'd3;
        for (int i = 0; i < 3; i++) begin
            bus.EX_RESULT = 32'h300 + 32'(i);
            push(5'd3, 32'h300 + 32'(i), 1'b0);
            tick();
        end
        bus.EX_VALID = 1'b0;
        push(5'd30, 32'h0000_0200, 1'b1);
        tick();
        check("irq2_ack", {31'h0, bus.IRQ_ACK}, 32'h1);
        bus.IRQ_SAVE = 1'b0;
        tick();

        // Reset while a load is outstanding discards it.
        bus.EX_VALID   = 1'b1;
        bus.EX_IS_LOAD = 1'b1;
        bus.EX_RD      = 5'd20;
        bus.EX_FUNCT3  = LW;
        bus.MEM_BUSY   = 1'b1;
        tick();
        bus.EX_VALID = 1'b0;
        bus.DEC_RS1  = 5'd20;
        #1 check("rl_hz_before", {31'h0, bus.HAZARD_STALL}, 32'h1);
        tick();
        RESET = 1'b1;
        tick();
        RESET            = 1'b0;
        bus.MEM_BUSY     = 1'b0;
        bus.MEM_READDATA = 32'h0000_0BAD;
        #1 check("rl_hz_after", {31'h0, bus.HAZARD_STALL}, 32'h0);
        check("rl_pstall", {31'h0, bus.PIPE_STALL}, 32'h0);
        tick();
        tick();
        check("rl_we",   {31'h0, bus.RF_WRITE_EN}, 32'h0);
        check("rl_in",   bus.RF_IN, 32'h0);
        check("rl_addr", {27'h0, bus.RF_INADDRESS}, 32'h0);
        check("rl_ack",  {31'h0, bus.IRQ_ACK}, 32'h0);

        repeat (3) tick();
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
